// File: rtl/jk_excitation_driver.sv
// Target-word FIFO feeding a JK excitation FSM: pop -> drive J/K for one cycle -> check Q.
// Define JK_TOGGLE_EN to drive changing bits with J=K=1 (toggle) instead of set/reset.
module jk_excitation_driver #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_target,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  input  logic [WIDTH-1:0] q_fb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             ready_en;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] exc_j;
  logic [WIDTH-1:0] exc_k;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             mismatch;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  // ready_en holds in_ready low until the first edge after reset release
  assign in_ready = ready_en && !full;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && ((state == IDLE) || (state == CHECK));
  assign head     = mem[rd_ptr];
  assign busy     = (state != IDLE) || !empty;
  assign mismatch = (q_fb != tgt);

`ifdef JK_TOGGLE_EN
  assign exc_j = q_fb ^ head;
  assign exc_k = q_fb ^ head;
`else
  assign exc_j = ~q_fb & head;
  assign exc_k = q_fb & ~head;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_target;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      j_out   <= '0;
      k_out   <= '0;
      tgt     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tgt   <= head;
            j_out <= exc_j;
            k_out <= exc_k;
            state <= DRIVE;
          end
        end
        DRIVE: begin
          // flip-flops capture at this edge; release drive so Q holds during CHECK
          j_out <= '0;
          k_out <= '0;
          state <= CHECK;
        end
        CHECK: begin
          done <= 1'b1;
          err  <= mismatch;
          if (mismatch && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
          if (pop) begin
            tgt   <= head;
            j_out <= exc_j;
            k_out <= exc_k;
            state <= DRIVE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: JK flip-flop bank closes the loop; a transaction-timing
// model (accept/pop/done edge arithmetic) predicts every output each cycle.
module tb_jk_excitation_driver;
  localparam int W  = 4;
  localparam int D  = 4;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          ff_rstn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_target = '0;
  logic [W-1:0]  j_out, k_out, q_fb, ff_q;
  logic [W-1:0]  mask = '0;
  logic          busy, done, err;
  logic [EW-1:0] err_cnt;
  int            vectors = 0;
  int            miscompares = 0;
  int            ready_low = 0;

  always #5 clk = ~clk;

  jk_excitation_driver #(.WIDTH(W), .DEPTH(D), .ERR_W(EW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_target(in_target), .j_out(j_out), .k_out(k_out), .q_fb(q_fb),
    .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
  );

  // external JK flip-flop bank; mask forces selected feedback bits to 0
  always @(posedge clk or negedge ff_rstn) begin
    if (!ff_rstn) ff_q <= '0;
    else
      for (int b = 0; b < W; b++)
        case ({j_out[b], k_out[b]})
          2'b10:   ff_q[b] <= 1'b1;
          2'b01:   ff_q[b] <= 1'b0;
          2'b11:   ff_q[b] <= ~ff_q[b];
          default: ff_q[b] <= ff_q[b];
        endcase
  end
  assign q_fb = ff_q & ~mask;

  function automatic logic [2*W-1:0] exc(input logic [W-1:0] q, input logic [W-1:0] t);
    logic [W-1:0] jv, kv;
    jv = '0;
    kv = '0;
    for (int b = 0; b < W; b++) begin
`ifdef JK_TOGGLE_EN
      if (q[b] != t[b]) begin jv[b] = 1'b1; kv[b] = 1'b1; end
`else
      if (!q[b] && t[b]) jv[b] = 1'b1;
      else if (q[b] && !t[b]) kv[b] = 1'b1;
`endif
    end
    return {jv, kv};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [W-1:0] t;
    int           a;
    int           p;
    logic [W-1:0] qin;
  } tx_t;

  tx_t           txq[$];
  int            cyc, last_p;
  logic          s_valid = 1'b0;
  logic [W-1:0]  s_tgt = '0, s_qfb = '0;
  logic          exp_ready, exp_busy, exp_done, exp_err;
  logic [W-1:0]  exp_j, exp_k;
  logic [EW-1:0] exp_cnt;

  // A word accepted at edge a pops at max(a+1, previous pop+2); done follows its pop by 2 edges.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      txq.delete();
      cyc = 0;
      last_p = -100;
      exp_ready = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
      exp_j = '0; exp_k = '0; exp_cnt = '0;
    end else begin
      tx_t nt;
      int occ, cand;
      logic [2*W-1:0] jk;
      cyc++;
      if (s_valid && exp_ready) begin
        nt.t = s_tgt; nt.a = cyc; nt.p = -1; nt.qin = '0;
        txq.push_back(nt);
      end
      exp_j = '0; exp_k = '0; exp_done = 1'b0; exp_err = 1'b0;
      for (int i = 0; i < txq.size(); i++) begin
        if (txq[i].p < 0) begin
          cand = (txq[i].a + 1 > last_p + 2) ? txq[i].a + 1 : last_p + 2;
          if (cand == cyc) begin
            txq[i].p = cyc;
            txq[i].qin = s_qfb;
            last_p = cyc;
            jk = exc(s_qfb, txq[i].t);
            exp_j = jk[2*W-1:W];
            exp_k = jk[W-1:0];
          end
          break;
        end
      end
      if (txq.size() > 0 && txq[0].p >= 0 && txq[0].p + 2 == cyc) begin
        exp_done = 1'b1;
        exp_err = (s_qfb != txq[0].t);
        if (exp_err && exp_cnt != '1) exp_cnt++;
        void'(txq.pop_front());
      end
      occ = 0;
      foreach (txq[i]) if (txq[i].p < 0) occ++;
      exp_ready = (occ < D);
      exp_busy = (txq.size() != 0);
    end
  end

  // every cycle: compare outputs, then capture inputs the next edge will see
  always @(negedge clk) begin
    check("in_ready", 8'(in_ready), 8'(exp_ready));
    check("j_out", 8'(j_out), 8'(exp_j));
    check("k_out", 8'(k_out), 8'(exp_k));
    check("busy", 8'(busy), 8'(exp_busy));
    check("done", 8'(done), 8'(exp_done));
    check("err", 8'(err), 8'(exp_err));
    check("err_cnt", 8'(err_cnt), 8'(exp_cnt));
    s_valid = in_valid;
    s_tgt   = in_target;
    s_qfb   = q_fb;
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [W-1:0] t);
    int n = 0;
    logic r;
    in_valid = 1'b1;
    in_target = t;
    forever begin
      @(negedge clk);
      r = in_ready;
      if (!r) ready_low++;
      @(posedge clk);
      n++;
      if (r) break;
      if (n > 40) begin
        vectors++; miscompares++;
        $display("FAIL push_timeout: got no in_ready, required in_ready within 40 cycles");
        break;
      end
    end
    #2;
  endtask

  task automatic wait_done(output logic e, output logic [EW-1:0] c);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 20);
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL wait_done: got no done, required done within 20 cycles");
    end
    e = err;
    c = err_cnt;
    sync();
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 60);
    if (busy) begin
      vectors++; miscompares++;
      $display("FAIL wait_idle: got busy=1, required busy=0 within 60 cycles");
    end
    sync();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_j"}, 8'(j_out), 8'd0);
    check({tag, "_k"}, 8'(k_out), 8'd0);
    check({tag, "_ready"}, 8'(in_ready), 8'd0);
    check({tag, "_busy"}, 8'(busy), 8'd0);
    check({tag, "_errcnt"}, 8'(err_cnt), 8'd0);
  endtask

  task automatic release_reset(input string tag);
    sync();
    rstn = 1'b1;
    #1 check({tag, "_ready_pre"}, 8'(in_ready), 8'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_ready_post"}, 8'(in_ready), 8'd1);
    sync();
  endtask

  task automatic drive_check(input string tag, input logic [W-1:0] t,
                             input logic [W-1:0] ej, input logic [W-1:0] ek);
    logic e;
    logic [EW-1:0] c;
    push(t);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_j"}, 8'(j_out), 8'(ej));
    check({tag, "_k"}, 8'(k_out), 8'(ek));
    @(negedge clk);
    check({tag, "_jk_clear"}, 8'({j_out, k_out}), 8'd0);
    wait_done(e, c);
    check({tag, "_err"}, 8'(e), 8'd0);
    check({tag, "_q"}, 8'(q_fb), 8'(t));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int seq [5];
    logic e;
    logic [EW-1:0] c;
    seq = '{1, 2, 3, 3, 3};

    #1 reset_checks("por");
    #20 ff_rstn = 1'b1;
    release_reset("por");

`ifdef JK_TOGGLE_EN
    drive_check("set1010", 4'b1010, 4'b1010, 4'b1010);
    drive_check("to0110", 4'b0110, 4'b1100, 4'b1100);
`else
    drive_check("set1010", 4'b1010, 4'b1010, 4'b0000);
    drive_check("to0110", 4'b0110, 4'b0100, 4'b1000);
`endif

    // burst longer than FIFO drain can keep up with
    ready_low = 0;
    push(4'b1111);
    push(4'b1110);
    for (int v = 1; v <= 6; v++) push(4'(v));
    in_valid = 1'b0;
    wait_idle();
    check("burst_ready_dropped", 8'(ready_low > 0), 8'd1);
    check("burst_final_q", 8'(q_fb), 8'b0110);
    check("burst_errcnt", 8'(err_cnt), 8'd0);

    // stuck-at-0 feedback on bit 0 with a 2-bit saturating counter
    mask = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      push(4'b0001);
      in_valid = 1'b0;
      wait_done(e, c);
      check("sat_err", 8'(e), 8'd1);
      check("sat_cnt", 8'(c), 8'(seq[i]));
    end
    mask = '0;
    sync();

    // reset while the popped target is being driven
    push(4'b1111);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 reset_checks("drive_rst");
    sync(); sync(); sync();
    release_reset("drive_rst");
    push(4'b0011);
    in_valid = 1'b0;
    wait_done(e, c);
    check("post_rst_err", 8'(e), 8'd0);
    check("post_rst_cnt", 8'(c), 8'd0);
    check("post_rst_q", 8'(q_fb), 8'b0011);

    // randomized traffic with alternating dense/sparse phases and occasional stuck bits
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ((i % 100) < 50) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      in_target = 4'($urandom);
      if ($urandom_range(0, 40) == 0) mask = ($urandom_range(0, 1) == 1) ? 4'($urandom) : '0;
      sync();
    end

    // asynchronous reset in the middle of traffic
    mask = '0;
    in_valid = 1'b1;
    in_target = 4'b0101;
    sync(); sync(); sync();
    rstn = 1'b0;
    #1 reset_checks("midrun");
    in_valid = 1'b0;
    sync(); sync();
    release_reset("midrun");
    for (int i = 0; i < 10; i++) sync();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
